// File: rtl/mult_accumulator.sv
// mult_accumulator: sums FRAME_LEN unsigned 64-bit products per frame and presents each sum with valid/ready
module mult_accumulator #(
  parameter int FRAME_LEN = 8,
  parameter int ACC_W = 72
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [63:0]      prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  input  logic             flush,
  output logic [ACC_W-1:0] acc_out,
  output logic             acc_valid,
  input  logic             acc_ready,
  output logic             overflow,
  output logic [7:0]       count_out
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;
  state_t state, state_next;
  logic accept, last;
  logic [ACC_W:0] sum;
  logic [7:0] count_inc;
  assign prod_ready = state != HOLD;
  assign acc_valid = state == HOLD;
  assign accept = prod_valid && prod_ready;
  assign sum = {1'b0, acc_out} + (ACC_W+1)'(prod_in);
  assign count_inc = state == IDLE ? 8'd1 : count_out + 8'd1;
  assign last = count_inc == 8'(FRAME_LEN) || flush;
  always_comb begin
    state_next = state;
    if (state == HOLD)
      state_next = acc_ready ? IDLE : HOLD;
    else if (accept)
      state_next = last ? HOLD : ACCUM;
    else if (state == ACCUM && flush)
      state_next = HOLD;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      acc_out <= '0;
      count_out <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        acc_out <= state == IDLE ? ACC_W'(prod_in) : sum[ACC_W-1:0];
        count_out <= count_inc;
        overflow <= state == IDLE ? 1'b0 : overflow | sum[ACC_W];
      end
    end
  end
endmodule

// File: tb/tb_mult_accumulator.sv
// tb_mult_accumulator: directed vectors with hand-computed sums for default and 64-bit/2-sample configurations
module tb_mult_accumulator;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [63:0] prod_in = '0;
  logic prod_valid = 1'b0, flush = 1'b0, acc_ready = 1'b0;
  logic prod_ready, acc_valid, overflow;
  logic [71:0] acc_out;
  logic [7:0] count_out;
  logic [63:0] prod_in2 = '0;
  logic prod_valid2 = 1'b0, flush2 = 1'b0, acc_ready2 = 1'b0;
  logic prod_ready2, acc_valid2, overflow2;
  logic [63:0] acc_out2;
  logic [7:0] count_out2;
  int n_checks = 0;
  int n_pass = 0;
  mult_accumulator dut (
    .clock(clock), .reset(reset), .prod_in(prod_in), .prod_valid(prod_valid),
    .prod_ready(prod_ready), .flush(flush), .acc_out(acc_out), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .overflow(overflow), .count_out(count_out)
  );
  mult_accumulator #(.FRAME_LEN(2), .ACC_W(64)) dut2 (
    .clock(clock), .reset(reset), .prod_in(prod_in2), .prod_valid(prod_valid2),
    .prod_ready(prod_ready2), .flush(flush2), .acc_out(acc_out2), .acc_valid(acc_valid2),
    .acc_ready(acc_ready2), .overflow(overflow2), .count_out(count_out2)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic send(input logic [63:0] v, input logic f);
    prod_in = v;
    prod_valid = 1'b1;
    flush = f;
    @(posedge clock);
    @(negedge clock);
    prod_valid = 1'b0;
    flush = 1'b0;
  endtask
  task automatic send2(input logic [63:0] v);
    prod_in2 = v;
    prod_valid2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    prod_valid2 = 1'b0;
  endtask
  task automatic release_frame();
    acc_ready = 1'b1;
    acc_ready2 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    acc_ready = 1'b0;
    acc_ready2 = 1'b0;
    check("release_valid", 128'(acc_valid), 128'(0));
  endtask
  initial begin
    int next, frames, last_c;
    logic took;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_acc", 128'(acc_out), 128'(0));
    check("rst_count", 128'(count_out), 128'(0));
    check("rst_ovf", 128'(overflow), 128'(0));
    check("rst_valid", 128'(acc_valid), 128'(0));
    check("rst_ready", 128'(prod_ready), 128'(1));
    for (int i = 0; i < 7; i++) send(64'd12321, 1'b0);
    check("f1_early_valid", 128'(acc_valid), 128'(0));
    send(64'd12321, 1'b0);
    check("f1_valid", 128'(acc_valid), 128'(1));
    check("f1_acc", 128'(acc_out), 128'(98568));
    check("f1_count", 128'(count_out), 128'(8));
    check("f1_ovf", 128'(overflow), 128'(0));
    check("f1_ready", 128'(prod_ready), 128'(0));
    release_frame();
    send(64'd500, 1'b0);
    send(64'd600, 1'b0);
    send(64'd700, 1'b1);
    check("flush_valid", 128'(acc_valid), 128'(1));
    check("flush_acc", 128'(acc_out), 128'(1800));
    check("flush_count", 128'(count_out), 128'(3));
    release_frame();
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    check("idle_flush_ignored", 128'(acc_valid), 128'(0));
    for (int i = 1; i <= 8; i++) send(64'(i), 1'b0);
    prod_in = 64'd1000;
    prod_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("hold_ready", 128'(prod_ready), 128'(0));
      check("hold_acc", 128'(acc_out), 128'(36));
      check("hold_count", 128'(count_out), 128'(8));
    end
    acc_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    acc_ready = 1'b0;
    check("hold_rel_valid", 128'(acc_valid), 128'(0));
    check("hold_rel_acc", 128'(acc_out), 128'(36));
    @(posedge clock);
    @(negedge clock);
    prod_valid = 1'b0;
    check("heldoff_acc", 128'(acc_out), 128'(1000));
    check("heldoff_count", 128'(count_out), 128'(1));
    send(64'd2000, 1'b1);
    check("heldoff_frame_valid", 128'(acc_valid), 128'(1));
    check("heldoff_frame_acc", 128'(acc_out), 128'(3000));
    check("heldoff_frame_count", 128'(count_out), 128'(2));
    release_frame();
    send2(64'h8000_0000_0000_0000);
    send2(64'h8000_0000_0000_0000);
    check("w64_valid", 128'(acc_valid2), 128'(1));
    check("w64_acc", 128'(acc_out2), 128'(0));
    check("w64_ovf", 128'(overflow2), 128'(1));
    check("w64_count", 128'(count_out2), 128'(2));
    release_frame();
    send2(64'd1);
    check("w64_ovf_cleared", 128'(overflow2), 128'(0));
    send2(64'd1);
    check("w64_acc2", 128'(acc_out2), 128'(2));
    check("w64_ovf2", 128'(overflow2), 128'(0));
    release_frame();
    for (int i = 0; i < 5; i++) send(64'd10, 1'b0);
    reset = 1'b1;
    prod_valid = 1'b1;
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    prod_valid = 1'b0;
    flush = 1'b0;
    check("midrst_acc", 128'(acc_out), 128'(0));
    check("midrst_count", 128'(count_out), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      @(negedge clock);
      check("midrst_no_valid", 128'(acc_valid), 128'(0));
    end
    for (int i = 0; i < 8; i++) send(64'd10, 1'b0);
    check("post_rst_valid", 128'(acc_valid), 128'(1));
    check("post_rst_acc", 128'(acc_out), 128'(80));
    release_frame();
    acc_ready = 1'b1;
    prod_valid = 1'b1;
    next = 1;
    prod_in = 64'(next);
    frames = 0;
    last_c = 0;
    for (int c = 0; c < 40 && frames < 3; c++) begin
      took = prod_ready;
      if (acc_valid) begin
        check("stream_acc", 128'(acc_out), 128'(64 * frames + 36));
        check("stream_count", 128'(count_out), 128'(8));
        if (frames > 0) check("stream_gap", 128'(c - last_c), 128'(9));
        last_c = c;
        frames++;
      end
      @(posedge clock);
      @(negedge clock);
      if (took) begin
        next++;
        prod_in = 64'(next);
      end
    end
    prod_valid = 1'b0;
    acc_ready = 1'b0;
    check("stream_frames", 128'(frames), 128'(3));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mult_accumulator.md
MULT_ACCUMULATOR -- requirements
Module: mult_accumulator

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 8: number of products summed per frame (legal range 1..255).
REQ-002 SHALL have parameter ACC_W, default 72: accumulator width (legal range 64..128).
REQ-003 SHALL have port clock  input  1: single clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port prod_in  input  64: unsigned product from the upstream 32x32 multiplier.
REQ-006 SHALL have port prod_valid  input  1: prod_in is valid this cycle.
REQ-007 SHALL have port prod_ready  output  1: block accepts prod_in this cycle.
REQ-008 SHALL have port flush  input  1: close the current frame early.
REQ-009 SHALL have port acc_out  output  ACC_W: frame sum.
REQ-010 SHALL have port acc_valid  output  1: acc_out holds a completed frame.
REQ-011 SHALL have port acc_ready  input  1: downstream accepts acc_out.
REQ-012 SHALL have port overflow  output  1: carry out of ACC_W occurred in the presented frame.
REQ-013 SHALL have port count_out  output  8: number of samples in the presented frame.

Function
REQ-014 SHALL implement states IDLE, ACCUM and HOLD.
REQ-015 SHALL define accept as prod_valid AND prod_ready.
REQ-016 SHALL drive prod_ready = 1 in IDLE and ACCUM, and 0 in HOLD.
REQ-017 In IDLE, on accept, SHALL load acc = zero-extended prod_in, set count = 1 and clear overflow.
REQ-018 On the IDLE accept of REQ-017, SHALL go to HOLD if count reaches FRAME_LEN or flush = 1, and to ACCUM otherwise.
REQ-019 In ACCUM, on accept, SHALL set acc = acc + prod_in modulo 2^ACC_W and count = count + 1, and SHALL set overflow if the addition carries out of bit ACC_W-1.
REQ-020 In ACCUM, SHALL go to HOLD in the same edge that count reaches FRAME_LEN.
REQ-021 Flush in ACCUM SHALL go to HOLD; if flush coincides with an accept, that sample SHALL be included before closing.
REQ-022 Flush in IDLE without an accept, and flush in HOLD, SHALL be ignored.
REQ-023 acc_valid SHALL be 1 exactly when the state is HOLD, i.e. it rises one cycle after the closing accept or flush.
REQ-024 acc_out, count_out and overflow SHALL be stable while acc_valid = 1.
REQ-025 In HOLD, when acc_ready = 1, SHALL go to IDLE; acc_valid SHALL be 0 in the next cycle.
REQ-026 Back-to-back frames SHALL cost one bubble cycle, for a throughput of FRAME_LEN samples per FRAME_LEN+1 cycles when acc_ready is held at 1.
REQ-027 prod_valid = 0 cycles SHALL leave acc and count unchanged in any state.
REQ-028 acc_out SHALL be the unsigned sum modulo 2^ACC_W; no saturation.
REQ-029 The overflow flag SHALL be sticky within a frame and cleared at the start of the next frame.

Reset
REQ-030 On a clock edge with reset = 1, SHALL enter IDLE with acc_out = 0, count_out = 0, overflow = 0 and acc_valid = 0.
REQ-031 After reset, prod_ready SHALL be 1 starting the first cycle after reset deasserts.
REQ-032 Reset SHALL take priority over prod_valid, flush and acc_ready.
REQ-033 Reset mid-frame (ACCUM) or in HOLD SHALL discard the partial or pending sum; no acc_valid pulse SHALL follow.

Verification
REQ-034 Defaults, 8 accepts of 12321 (111*111) -> acc_valid one cycle after the 8th accept; acc_out = 98568, count_out = 8, overflow = 0.
REQ-035 Samples 500, 600, 700 with flush on the 3rd accept -> acc_out = 1800, count_out = 3, acc_valid after 1 cycle.
REQ-036 acc_ready held at 0 for 5 cycles in HOLD while prod_valid = 1 -> prod_ready = 0, acc_out is stable and no samples are lost; after release, the next frame starts from the held-off sample.
REQ-037 ACC_W = 64, FRAME_LEN = 2, samples 2^63 and 2^63 -> acc_out = 0, overflow = 1; the next frame of 1 and 1 -> acc_out = 2, overflow = 0.
REQ-038 Reset asserted after 5 of 8 accepts -> no acc_valid; a subsequent full frame of 8 x 10 gives acc_out = 80.
REQ-039 Continuous prod_valid with acc_ready = 1 -> exactly one bubble between frames, and frame sums are correct across 3 frames.
